// File: rtl/sap1_prog_loader.sv
// ---------------------------------------------------------------------------
// sap1_prog_loader
//
// Front-panel replacement for the SAP-1 CPU. The loader keeps the CPU stopped
// while it accepts program bytes from a host over a valid/ready stream and
// writes them into the program memory. Once loading is complete (all DEPTH
// bytes, or an early run request), it issues a single-cycle CPU clear and
// then lets the CPU run.
//
// Parameters
//   ADDR_W  memory address width
//   DATA_W  memory word / bus width
//   DEPTH   number of locations loaded; must equal 2**ADDR_W
//
// Ports
//   clk         system clock, rising edge
//   clr         synchronous active-high reset
//   load_req    start a load (acted on in IDLE and RUN)
//   run_req     start the CPU without loading (IDLE) / end a load early (LOAD)
//   in_data     program byte from the host
//   in_valid    in_data is valid
//   in_ready    loader takes in_data this cycle (decoded from registers only)
//   ram_addr    memory write address (registered)
//   ram_wdata   memory write data (registered)
//   ram_we      memory write strobe, one cycle per byte (registered)
//   cpu_hold    1 = CPU clock gated off
//   cpu_clr     one-cycle CPU clear pulse
//   busy        1 while loading or releasing
//   done        1 while the CPU runs
//   byte_count  bytes accepted in the current/last load, 0..DEPTH
// ---------------------------------------------------------------------------
module sap1_prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load_req,
  input  logic              run_req,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              cpu_hold,
  output logic              cpu_clr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   byte_count
);

  // byte_count is one bit wider than the address so it can hold DEPTH itself.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] ZERO_C  = (ADDR_W+1)'(0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W:0]     count_r;
  logic [ADDR_W:0]     count_nxt_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                we_r;
  logic                in_ready_s;
  logic                xfer_s;

  // Handshake qualifiers: in_ready depends only on registered state so the
  // host never sees a combinational path from its own inputs.
  always_comb begin
    in_ready_s = (state_r == ST_LOAD) && (count_r < DEPTH_C);
    xfer_s     = in_ready_s && in_valid;
  end

  // Next-state and byte-count logic.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    case (state_r)
      ST_IDLE: begin
        // load_req has priority when both requests arrive together.
        if (load_req) begin
          state_nxt_s = ST_LOAD;
          count_nxt_s = ZERO_C;
        end else if (run_req) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (xfer_s) begin
          count_nxt_s = count_r + ONE_C;
          // The final byte or a concurrent run_req ends the load; the byte
          // accepted this cycle is still written.
          if ((count_r == LAST_C) || run_req) begin
            state_nxt_s = ST_RELEASE;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end else if (run_req) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_RELEASE: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        // A reload halts the CPU at once and restarts from address 0.
        if (load_req) begin
          state_nxt_s = ST_LOAD;
          count_nxt_s = ZERO_C;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        count_nxt_s = ZERO_C;
      end
    endcase
  end

  // Control state and byte counter registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= ST_IDLE;
      count_r <= ZERO_C;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Memory write port: each accepted byte becomes a one-cycle strobe on the
  // following cycle; address/data hold their last value between writes.
  always_ff @(posedge clk) begin
    if (clr) begin
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
    end else if (xfer_s) begin
      we_r    <= 1'b1;
      addr_r  <= count_r[ADDR_W-1:0];
      wdata_r <= in_data;
    end else begin
      we_r    <= 1'b0;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // Output decode from the state register.
  always_comb begin
    in_ready   = in_ready_s;
    cpu_hold   = (state_r != ST_RUN);
    cpu_clr    = (state_r == ST_RELEASE);
    busy       = (state_r == ST_LOAD) || (state_r == ST_RELEASE);
    done       = (state_r == ST_RUN);
    ram_we     = we_r;
    ram_addr   = addr_r;
    ram_wdata  = wdata_r;
    byte_count = count_r;
  end

endmodule

// File: tb/tb_sap1_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_sap1_prog_loader
//
// Directed bench for sap1_prog_loader. A cycle-level behavioural model of the
// loader (phase flags, an integer byte count and an expected memory image)
// runs beside the DUT; one compare process checks every output against it on
// each falling edge. Directed scenarios add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_sap1_prog_loader;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       load_req = 1'b0;
  logic       run_req = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b1;
  logic       in_ready;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic       cpu_hold;
  logic       cpu_clr;
  logic       busy;
  logic       done;
  logic [4:0] byte_count;

  sap1_prog_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
    .clk        (clk),
    .clr        (clr),
    .load_req   (load_req),
    .run_req    (run_req),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .cpu_hold   (cpu_hold),
    .cpu_clr    (cpu_clr),
    .busy       (busy),
    .done       (done),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int clr_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: which phase the loader is in, how many bytes it has
  // taken, and what the write port must show next.
  bit         m_loading   = 1'b0;
  bit         m_releasing = 1'b0;
  bit         m_running   = 1'b0;
  int         m_count     = 0;
  bit         m_we        = 1'b0;
  logic [3:0] m_addr      = 4'h0;
  logic [7:0] m_data      = 8'h00;
  logic [7:0] m_mem [16];
  logic [7:0] tb_mem [16];

  function automatic bit m_ready();
    return m_loading && (m_count < 16);
  endfunction

  always @(posedge clk) begin
    bit hs;
    hs = m_ready() && in_valid;
    if (clr) begin
      m_loading <= 1'b0; m_releasing <= 1'b0; m_running <= 1'b0;
      m_count <= 0; m_we <= 1'b0; m_addr <= 4'h0; m_data <= 8'h00;
    end else begin
      m_we <= hs;
      if (hs) begin
        m_addr <= m_count[3:0];
        m_data <= in_data;
        m_mem[m_count] <= in_data;
      end
      if (!m_loading && !m_releasing && !m_running) begin
        if (load_req) begin m_loading <= 1'b1; m_count <= 0; end
        else if (run_req) m_releasing <= 1'b1;
      end else if (m_loading) begin
        if (hs) m_count <= m_count + 1;
        if ((hs && m_count + 1 == 16) || run_req) begin
          m_loading <= 1'b0; m_releasing <= 1'b1;
        end
      end else if (m_releasing) begin
        m_releasing <= 1'b0; m_running <= 1'b1;
      end else if (load_req) begin
        m_running <= 1'b0; m_loading <= 1'b1; m_count <= 0;
      end
    end
  end

  // Program memory as seen by the CPU, fed only by the DUT's write port.
  always @(posedge clk) begin
    if (ram_we) tb_mem[ram_addr] <= ram_wdata;
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cpu_clr) clr_seen++;
    chk("in_ready",   {31'd0, in_ready},   {31'd0, m_ready()});
    chk("cpu_hold",   {31'd0, cpu_hold},   {31'd0, !m_running});
    chk("cpu_clr",    {31'd0, cpu_clr},    {31'd0, m_releasing});
    chk("busy",       {31'd0, busy},       {31'd0, m_loading || m_releasing});
    chk("done",       {31'd0, done},       {31'd0, m_running});
    chk("byte_count", {27'd0, byte_count}, m_count);
    chk("ram_we",     {31'd0, ram_we},     {31'd0, m_we});
    chk("ram_addr",   {28'd0, ram_addr},   {28'd0, m_addr});
    chk("ram_wdata",  {24'd0, ram_wdata},  {24'd0, m_data});
  end

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic pulse_load();
    load_req = 1'b1; cyc(1); load_req = 1'b0;
  endtask

  // Offer one byte and hold it until the loader takes it.
  task automatic send(input logic [7:0] d);
    int t;
    in_data = d; in_valid = 1'b1; t = 0;
    while (!m_ready() && t < 40) begin cyc(1); t++; end
    chk("send_timeout", {31'd0, (t < 40)}, 32'd1);
    cyc(1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 20) begin cyc(1); t++; end
    chk("done_timeout", {31'd0, (t < 20)}, 32'd1);
  endtask

  initial begin
    int base;
    int taken;
    bit v;
    logic [7:0] d;

    // 1. Reset held two cycles with in_valid high.
    cyc(2);
    chk("rst_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_we",    {31'd0, ram_we},   32'd0);
    chk("rst_addr",  {28'd0, ram_addr}, 32'd0);
    chk("rst_count", {27'd0, byte_count}, 32'd0);
    chk("rst_done",  {31'd0, done},     32'd0);
    clr = 1'b0; in_valid = 1'b0;
    cyc(2);

    // 2. Full load, valid held high throughout.
    base = clr_seen;
    pulse_load();
    for (int i = 0; i < 16; i++) begin
      d = 8'(8'h09 + 8'h11 * i);
      send(d);
    end
    chk("full_ready_after16", {31'd0, in_ready}, 32'd0);
    wait_done();
    in_valid = 1'b0;
    cyc(1);
    chk("full_count", {27'd0, byte_count}, 32'd16);
    chk("full_clr_pulses", clr_seen - base, 32'd1);
    chk("full_hold", {31'd0, cpu_hold}, 32'd0);
    chk("full_mem0",  {24'd0, tb_mem[0]},  32'h09);
    chk("full_mem1",  {24'd0, tb_mem[1]},  32'h1A);
    chk("full_mem15", {24'd0, tb_mem[15]}, 32'h08);

    // 3. Backpressure: valid toggles every cycle, then stays high past 16.
    pulse_load();
    taken = 0; v = 1'b1;
    for (int c = 0; c < 80 && taken < 16; c++) begin
      in_valid = v;
      in_data  = 8'(8'hA0 + taken);
      if (v && m_ready()) taken++;
      cyc(1);
      v = !v;
    end
    chk("bp_taken", taken, 32'd16);
    in_valid = 1'b1; in_data = 8'hFF;
    chk("bp_ready_after16", {31'd0, in_ready}, 32'd0);
    wait_done();
    in_valid = 1'b0;
    chk("bp_mem3",  {24'd0, tb_mem[3]},  32'hA3);
    chk("bp_mem15", {24'd0, tb_mem[15]}, 32'hAF);

    // 4. Early run after three bytes.
    base = clr_seen;
    pulse_load();
    send(8'h1E); send(8'h2F); send(8'hE0);
    in_valid = 1'b0; run_req = 1'b1; cyc(1); run_req = 1'b0;
    wait_done();
    cyc(1);
    chk("early_count", {27'd0, byte_count}, 32'd3);
    chk("early_clr_pulses", clr_seen - base, 32'd1);
    chk("early_mem0", {24'd0, tb_mem[0]}, 32'h1E);
    chk("early_mem2", {24'd0, tb_mem[2]}, 32'hE0);
    chk("early_mem3_untouched", {24'd0, tb_mem[3]}, 32'hA3);

    // 5. Reset in the middle of a load, then restart.
    pulse_load();
    for (int i = 0; i < 5; i++) send(8'(8'h50 + i));
    in_valid = 1'b0; cyc(1);
    clr = 1'b1; in_valid = 1'b1; cyc(1); clr = 1'b0; in_valid = 1'b0;
    chk("midrst_count", {27'd0, byte_count}, 32'd0);
    chk("midrst_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("midrst_busy",  {31'd0, busy}, 32'd0);
    cyc(1);
    chk("midrst_we", {31'd0, ram_we}, 32'd0);
    pulse_load();
    send(8'h77); send(8'h78);
    in_valid = 1'b0;
    chk("restart_addr", {28'd0, ram_addr}, 32'd1);
    run_req = 1'b1; cyc(1); run_req = 1'b0;
    wait_done();
    chk("restart_mem0", {24'd0, tb_mem[0]}, 32'h77);
    chk("restart_mem4", {24'd0, tb_mem[4]}, 32'h54);
    chk("restart_mem5", {24'd0, tb_mem[5]}, 32'hA5);

    // 6. Reload from RUN with both requests high.
    base = clr_seen;
    load_req = 1'b1; run_req = 1'b1; cyc(1); load_req = 1'b0; run_req = 1'b0;
    chk("reload_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("reload_busy",  {31'd0, busy}, 32'd1);
    chk("reload_count", {27'd0, byte_count}, 32'd0);
    cyc(3);
    chk("reload_no_clr", clr_seen - base, 32'd0);
    for (int i = 0; i < 16; i++) send(8'(8'hC0 + i));
    in_valid = 1'b0;
    wait_done();
    cyc(1);
    chk("reload_clr_pulses", clr_seen - base, 32'd1);
    chk("reload_count_end", {27'd0, byte_count}, 32'd16);

    // Memory image must match what the model expects for every location.
    for (int a = 0; a < 16; a++) chk("mem_image", {24'd0, tb_mem[a]}, {24'd0, m_mem[a]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
